// File: rtl/bram_fb_writer_pkg.sv
// Shared definitions for the frame-buffer writer and the BRAM read-side display controller.
// Holds the frame geometry defaults, the writer FSM states and RGB565 packing.
package bram_fb_writer_pkg;

    localparam int DEF_HSIZE = 320;
    localparam int DEF_VSIZE = 240;
    localparam int FB_ADDR_W = 18;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } fb_state_t;

    function automatic logic [15:0] pack_rgb565(input logic [7:0] r,
                                                input logic [7:0] g,
                                                input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Column/row position tracker producing the BRAM address of the pixel being accepted.
// The row base steps by +/-HSIZE per line, so no runtime multiplier is needed.
module fb_addr_gen
    import bram_fb_writer_pkg::*;
#(
    parameter int HSIZE = DEF_HSIZE,
    parameter int VSIZE = DEF_VSIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 restart,
    input  logic                 step,
    input  logic                 rev,
    output logic [FB_ADDR_W-1:0] addr,
    output logic                 last
);

    localparam logic [FB_ADDR_W-1:0] H_LAST   = FB_ADDR_W'(HSIZE - 1);
    localparam logic [FB_ADDR_W-1:0] V_LAST   = FB_ADDR_W'(VSIZE - 1);
    localparam logic [FB_ADDR_W-1:0] H_STEP   = FB_ADDR_W'(HSIZE);
    localparam logic [FB_ADDR_W-1:0] BASE_REV = FB_ADDR_W'((VSIZE - 1) * HSIZE);

    logic [FB_ADDR_W-1:0] col, row, row_base;
    logic [FB_ADDR_W-1:0] cur_col, cur_row, cur_base;

    // A restarting pixel always sits at column 0, row 0 regardless of stored position.
    always_comb begin
        cur_col  = col;
        cur_row  = row;
        cur_base = row_base;
        if (restart) begin
            cur_col  = '0;
            cur_row  = '0;
            cur_base = rev ? BASE_REV : '0;
        end
    end

    assign addr = cur_base + cur_col;
    assign last = (cur_col == H_LAST) && (cur_row == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            row_base <= '0;
        end else if (restart || step) begin
            if (cur_col == H_LAST) begin
                col      <= '0;
                row      <= cur_row + 1'b1;
                row_base <= rev ? (cur_base - H_STEP) : (cur_base + H_STEP);
            end else begin
                col      <= cur_col + 1'b1;
                row      <= cur_row;
                row_base <= cur_base;
            end
        end
    end

endmodule

// File: rtl/bram_fb_writer.sv
// Streams RGB888 pixels into a BRAM frame buffer as RGB565, optionally flipped vertically.
// Frames start on SOF; pixels before the first SOF are dropped and counted.
module bram_fb_writer
    import bram_fb_writer_pkg::*;
#(
    parameter int HSIZE = DEF_HSIZE,
    parameter int VSIZE = DEF_VSIZE
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 ENABLE,
    input  logic                 REVERSE_SW,
    input  logic                 PIX_VALID,
    output logic                 PIX_READY,
    input  logic                 PIX_SOF,
    input  logic [7:0]           PIX_R,
    input  logic [7:0]           PIX_G,
    input  logic [7:0]           PIX_B,
    output logic                 BRAMCLK,
    output logic [FB_ADDR_W-1:0] BRAMADDR,
    output logic [15:0]          BRAMWDATA,
    output logic                 BRAMWE,
    output logic                 FRAME_DONE,
    output logic                 SOF_ERR,
    output logic [15:0]          DROP_CNT
);

    if (HSIZE < 1 || VSIZE < 1 || HSIZE * VSIZE > 262144) begin : g_size_check
        $error("bram_fb_writer: HSIZE*VSIZE must be between 1 and 262144");
    end

    fb_state_t            state, state_n;
    logic                 accept, sof_acc, step, write;
    logic                 rev_lat, rev_cur, last, done_n;
    logic [FB_ADDR_W-1:0] addr;

    assign PIX_READY = ENABLE;
    assign BRAMCLK   = CLK;

    assign accept  = PIX_VALID & ENABLE;
    assign sof_acc = accept & PIX_SOF;
    assign step    = accept & ~PIX_SOF & (state == ACTIVE);
    assign write   = sof_acc | step;
    assign rev_cur = sof_acc ? REVERSE_SW : rev_lat;

    fb_addr_gen #(
        .HSIZE(HSIZE),
        .VSIZE(VSIZE)
    ) u_addr_gen (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .restart(sof_acc),
        .step   (step),
        .rev    (rev_cur),
        .addr   (addr),
        .last   (last)
    );

    // SOF wins over frame completion, so a last pixel carrying SOF never signals done.
    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        if (sof_acc) begin
            state_n = ACTIVE;
        end else if (step && last) begin
            state_n = WAIT_SOF;
            done_n  = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= WAIT_SOF;
            rev_lat    <= 1'b0;
            SOF_ERR    <= 1'b0;
            DROP_CNT   <= '0;
            BRAMWE     <= 1'b0;
            FRAME_DONE <= 1'b0;
            BRAMADDR   <= '0;
            BRAMWDATA  <= '0;
        end else begin
            state      <= state_n;
            BRAMWE     <= write;
            FRAME_DONE <= done_n;
            if (sof_acc) begin
                rev_lat <= REVERSE_SW;
            end
            if (sof_acc && state == ACTIVE) begin
                SOF_ERR <= 1'b1;
            end
            if (accept && !PIX_SOF && state == WAIT_SOF && DROP_CNT != 16'hFFFF) begin
                DROP_CNT <= DROP_CNT + 16'd1;
            end
            if (write) begin
                BRAMADDR  <= addr;
                BRAMWDATA <= pack_rgb565(PIX_R, PIX_G, PIX_B);
            end
        end
    end

endmodule

// File: tb/tb_bram_fb_writer.sv
// Directed bench for bram_fb_writer on a 4x3 frame; expected writes are queued by the
// stimulus and popped by an independent monitor whenever BRAMWE is seen.
module tb_bram_fb_writer;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        ENABLE = 1'b0;
    logic        REVERSE_SW = 1'b0;
    logic        PIX_VALID = 1'b0;
    logic        PIX_READY;
    logic        PIX_SOF = 1'b0;
    logic [7:0]  PIX_R = '0;
    logic [7:0]  PIX_G = '0;
    logic [7:0]  PIX_B = '0;
    logic        BRAMCLK;
    logic [17:0] BRAMADDR;
    logic [15:0] BRAMWDATA;
    logic        BRAMWE;
    logic        FRAME_DONE;
    logic        SOF_ERR;
    logic [15:0] DROP_CNT;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [17:0] addr;
        logic [15:0] data;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   rev_tab[12] = '{8, 9, 10, 11, 4, 5, 6, 7, 0, 1, 2, 3};

    bram_fb_writer #(
        .HSIZE(4),
        .VSIZE(3)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .ENABLE    (ENABLE),
        .REVERSE_SW(REVERSE_SW),
        .PIX_VALID (PIX_VALID),
        .PIX_READY (PIX_READY),
        .PIX_SOF   (PIX_SOF),
        .PIX_R     (PIX_R),
        .PIX_G     (PIX_G),
        .PIX_B     (PIX_B),
        .BRAMCLK   (BRAMCLK),
        .BRAMADDR  (BRAMADDR),
        .BRAMWDATA (BRAMWDATA),
        .BRAMWE    (BRAMWE),
        .FRAME_DONE(FRAME_DONE),
        .SOF_ERR   (SOF_ERR),
        .DROP_CNT  (DROP_CNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] rgb565(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Monitor: every write must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (BRAMWE === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %h, expected no write",
                         BRAMADDR, BRAMWDATA);
            end else begin
                mon_e = exp_q.pop_front();
                if (BRAMADDR !== mon_e.addr || BRAMWDATA !== mon_e.data ||
                    FRAME_DONE !== mon_e.done) begin
                    n_fail++;
                    $display("FAIL write: got addr %0d data %h done %b, expected addr %0d data %h done %b",
                             BRAMADDR, BRAMWDATA, FRAME_DONE, mon_e.addr, mon_e.data, mon_e.done);
                end
            end
        end else if (FRAME_DONE !== 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_done_without_we: got %b, expected 0", FRAME_DONE);
        end
    end

    task automatic send(input bit sof, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input bit wr, input logic [17:0] a,
                        input logic [15:0] d, input bit dn);
        exp_t e;
        PIX_VALID = 1'b1;
        PIX_SOF   = sof;
        PIX_R     = r;
        PIX_G     = g;
        PIX_B     = b;
        if (wr) begin
            e.addr = a;
            e.data = d;
            e.done = dn;
            exp_q.push_back(e);
        end
        @(posedge CLK);
        #1;
        PIX_VALID = 1'b0;
        PIX_SOF   = 1'b0;
    endtask

    task automatic px(input int i, input bit sof, input bit wr, input int a, input bit dn);
        logic [7:0] r, g, b;
        r = 8'(i * 37 + 11);
        g = 8'(i * 53 + 5);
        b = 8'(i * 71 + 3);
        send(sof, r, g, b, wr, 18'(a), rgb565(r, g, b), dn);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check("reset_we", 32'(BRAMWE), 0);
        check("reset_addr", 32'(BRAMADDR), 0);
        check("reset_wdata", 32'(BRAMWDATA), 0);
        check("reset_done", 32'(FRAME_DONE), 0);
        check("reset_sof_err", 32'(SOF_ERR), 0);
        check("reset_drop", 32'(DROP_CNT), 0);
        RESET_N = 1'b1;
        ENABLE  = 1'b1;
        @(posedge CLK);
        #1;
        check("ready_follows_enable", 32'(PIX_READY), 1);

        // Forward frame; the SOF pixel doubles as the packing vector.
        send(1'b1, 8'hFF, 8'h80, 8'h08, 1'b1, 18'd0, 16'hFC01, 1'b0);
        for (int i = 1; i < 12; i++) px(i, 1'b0, 1'b1, i, i == 11);

        // Reverse frame; flipping the switch mid-frame must not matter.
        REVERSE_SW = 1'b1;
        px(0, 1'b1, 1'b1, rev_tab[0], 1'b0);
        REVERSE_SW = 1'b0;
        for (int i = 1; i < 12; i++) px(i, 1'b0, 1'b1, rev_tab[i], i == 11);

        // Pre-SOF drops, then a frame broken by a second SOF at pixel 6.
        for (int i = 0; i < 5; i++) px(40 + i, 1'b0, 1'b0, 0, 1'b0);
        check("drop_cnt_5", 32'(DROP_CNT), 5);
        px(0, 1'b1, 1'b1, 0, 1'b0);
        for (int i = 1; i < 6; i++) px(i, 1'b0, 1'b1, i, 1'b0);
        check("sof_err_clear", 32'(SOF_ERR), 0);
        px(6, 1'b1, 1'b1, 0, 1'b0);
        check("sof_err_set", 32'(SOF_ERR), 1);
        for (int i = 1; i < 12; i++) px(20 + i, 1'b0, 1'b1, i, i == 11);
        check("sof_err_sticky", 32'(SOF_ERR), 1);
        check("drop_cnt_hold", 32'(DROP_CNT), 5);

        // Stall at pixel 5, resume, then reset mid-frame.
        px(0, 1'b1, 1'b1, 0, 1'b0);
        for (int i = 1; i < 5; i++) px(i, 1'b0, 1'b1, i, 1'b0);
        ENABLE    = 1'b0;
        PIX_VALID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_ready", 32'(PIX_READY), 0);
            @(posedge CLK);
            #1;
        end
        PIX_VALID = 1'b0;
        ENABLE    = 1'b1;
        px(5, 1'b0, 1'b1, 5, 1'b0);
        px(6, 1'b0, 1'b1, 6, 1'b0);
        @(negedge CLK);
        #1;
        RESET_N = 1'b0;
        #1;
        check("midreset_we", 32'(BRAMWE), 0);
        check("midreset_addr", 32'(BRAMADDR), 0);
        check("midreset_wdata", 32'(BRAMWDATA), 0);
        check("midreset_done", 32'(FRAME_DONE), 0);
        check("midreset_sof_err", 32'(SOF_ERR), 0);
        check("midreset_drop", 32'(DROP_CNT), 0);
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        for (int i = 7; i < 10; i++) px(i, 1'b0, 1'b0, 0, 1'b0);
        check("post_reset_drop", 32'(DROP_CNT), 3);
        px(0, 1'b1, 1'b1, 0, 1'b0);
        for (int i = 1; i < 12; i++) px(60 + i, 1'b0, 1'b1, i, i == 11);

        repeat (3) @(posedge CLK);
        #1;
        check("pending_writes", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
